// File: rtl/priority_encoder_n.sv
// priority_encoder_n: registered N-input priority encoder with sticky request
// capture, a valid/ready output slot and fixed-priority or round-robin selection.
//
// Handshake: out_valid says encoded_out/grant_onehot name a pending channel.
// A transfer happens on a rising edge where out_valid and out_ready are both
// high. While out_valid is high and out_ready is low, the presented index is
// frozen, and a newer request cannot preempt it. out_valid never depends
// combinationally on out_ready.
module priority_encoder_n #(
    parameter int N       = 8,
    parameter int RR_MODE = 0,
    localparam int IDX_W  = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req_in,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [IDX_W-1:0] encoded_out,
    output logic [N-1:0]     grant_onehot,
    output logic [N-1:0]     pending,
    output logic             busy
);

    logic [N-1:0]     pending_q, pending_d;
    logic             valid_q, valid_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;

    logic             acc;
    logic [N-1:0]     grant_oh;
    logic [N-1:0]     clr_mask;
    logic [N-1:0]     cand;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] sel_fix, sel_lo, sel_hi;
    logic             hit_hi;

    assign acc      = valid_q & out_ready;
    assign clr_mask = acc ? grant_oh : '0;
    // Only already-captured requests compete; a request arriving this cycle
    // waits one cycle before it can be selected.
    assign cand     = pending_q & ~clr_mask;

    // Decode the registered index into a one-hot grant, zero when idle.
    always_comb begin
        grant_oh = '0;
        for (int i = 0; i < N; i++) begin
            if (valid_q && (idx_q == IDX_W'(i))) begin
                grant_oh[i] = 1'b1;
            end
        end
    end

    // Pick the winner: highest index (fixed) or first index at/after ptr (RR).
    always_comb begin
        sel_fix = '0;
        sel_lo  = '0;
        sel_hi  = '0;
        hit_hi  = 1'b0;
        // Ascending scan: the last hit is the highest set index.
        for (int i = 0; i < N; i++) begin
            if (cand[i]) begin
                sel_fix = IDX_W'(i);
            end
        end
        // Descending scan: the last hit is the lowest set index overall (wrap
        // fallback) and the lowest set index at or above the pointer.
        for (int i = N - 1; i >= 0; i--) begin
            if (cand[i]) begin
                sel_lo = IDX_W'(i);
                if (IDX_W'(i) >= ptr_q) begin
                    sel_hi = IDX_W'(i);
                    hit_hi = 1'b1;
                end
            end
        end
        if (RR_MODE != 0) begin
            sel = hit_hi ? sel_hi : sel_lo;
        end else begin
            sel = sel_fix;
        end
    end

    // Next-state: sticky pending (set wins), output slot reload, RR pointer.
    always_comb begin
        pending_d = (pending_q & ~clr_mask) | req_in;
        valid_d   = valid_q;
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        // The slot reloads only when empty or being emptied this edge.
        if (!valid_q || acc) begin
            if (|cand) begin
                valid_d = 1'b1;
                idx_d   = sel;
            end else begin
                valid_d = 1'b0;
            end
        end
        // The pointer moves just past the accepted channel, wrapping at N.
        if ((RR_MODE != 0) && acc) begin
            if (idx_q == IDX_W'(N - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = idx_q + 1'b1;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q <= '0;
            valid_q   <= 1'b0;
            idx_q     <= '0;
            ptr_q     <= '0;
        end else begin
            pending_q <= pending_d;
            valid_q   <= valid_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
        end
    end

    assign out_valid    = valid_q;
    assign encoded_out  = idx_q;
    assign grant_onehot = grant_oh;
    assign pending      = pending_q;
    assign busy         = (|pending_q) | valid_q;

endmodule

// File: tb/tb_priority_encoder_n.sv
// Bench for priority_encoder_n: one fixed-priority and one round-robin instance,
// directed pulses, a per-instance expected-index queue drained by a monitor.
module tb_priority_encoder_n;

    localparam int N = 8;

    logic       clk;
    logic       rst;

    logic [7:0] fx_req, rr_req;
    logic       fx_rdy, rr_rdy;
    logic       fx_valid, rr_valid;
    logic [2:0] fx_enc, rr_enc;
    logic [7:0] fx_grant, rr_grant;
    logic [7:0] fx_pend, rr_pend;
    logic       fx_busy, rr_busy;

    logic [2:0] exp_fx[$];
    logic [2:0] exp_rr[$];

    int n_checks = 0;
    int n_fail   = 0;

    priority_encoder_n #(.N(N), .RR_MODE(0)) dut_fx (
        .clk(clk), .rst(rst), .req_in(fx_req), .out_ready(fx_rdy),
        .out_valid(fx_valid), .encoded_out(fx_enc), .grant_onehot(fx_grant),
        .pending(fx_pend), .busy(fx_busy)
    );

    priority_encoder_n #(.N(N), .RR_MODE(1)) dut_rr (
        .clk(clk), .rst(rst), .req_in(rr_req), .out_ready(rr_rdy),
        .out_valid(rr_valid), .encoded_out(rr_enc), .grant_onehot(rr_grant),
        .pending(rr_pend), .busy(rr_busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- scoreboard monitors ----------------
    // A transfer is sampled at the negedge before the edge that completes it.
    always @(negedge clk) begin
        logic [2:0] e;
        logic [7:0] oh;
        if (!rst && fx_valid && fx_rdy) begin
            if (exp_fx.size() == 0) begin
                check("fx_sb_unexpected", 32'(fx_enc), 32'hFFFF);
            end else begin
                e  = exp_fx.pop_front();
                oh = 8'd1 << e;
                check("fx_sb_idx", 32'(fx_enc), 32'(e));
                check("fx_sb_grant", 32'(fx_grant), 32'(oh));
            end
        end
        if (!rst && rr_valid && rr_rdy) begin
            if (exp_rr.size() == 0) begin
                check("rr_sb_unexpected", 32'(rr_enc), 32'hFFFF);
            end else begin
                e  = exp_rr.pop_front();
                oh = 8'd1 << e;
                check("rr_sb_idx", 32'(rr_enc), 32'(e));
                check("rr_sb_grant", 32'(rr_grant), 32'(oh));
            end
        end
    end

    // ---------------- driver ----------------
    // Apply inputs for exactly one rising edge; return 2 time units after it.
    task automatic cyc_fx(input logic [7:0] req, input logic rdy);
        fx_req = req; fx_rdy = rdy; rr_req = 8'h00; rr_rdy = 1'b1;
        @(posedge clk); #2;
    endtask

    task automatic cyc_rr(input logic [7:0] req, input logic rdy);
        rr_req = req; rr_rdy = rdy; fx_req = 8'h00; fx_rdy = 1'b1;
        @(posedge clk); #2;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1;
        fx_req = 8'hFF; rr_req = 8'hFF; fx_rdy = 1'b1; rr_rdy = 1'b1;

        // 1. Reset holds everything idle even with all requests high.
        repeat (2) @(posedge clk);
        #2;
        check("rst_fx_valid", 32'(fx_valid), 0);
        check("rst_fx_pending", 32'(fx_pend), 0);
        check("rst_fx_busy", 32'(fx_busy), 0);
        check("rst_fx_enc", 32'(fx_enc), 0);
        check("rst_fx_grant", 32'(fx_grant), 0);
        check("rst_rr_pending", 32'(rr_pend), 0);
        fx_req = 8'h00; rr_req = 8'h00;
        rst = 1'b0;
        cyc_fx(8'h00, 1'b1);
        cyc_fx(8'h00, 1'b1);
        check("idle_fx_valid", 32'(fx_valid), 0);
        check("idle_fx_busy", 32'(fx_busy), 0);
        check("idle_rr_busy", 32'(rr_busy), 0);

        // 2. Fixed priority: pulse bits 7 and 5.
        exp_fx.push_back(3'd7);
        exp_fx.push_back(3'd5);
        cyc_fx(8'hA0, 1'b1);
        check("fp_pending", 32'(fx_pend), 32'hA0);
        check("fp_valid_late", 32'(fx_valid), 0);
        cyc_fx(8'h00, 1'b1);
        check("fp_valid", 32'(fx_valid), 1);
        check("fp_enc7", 32'(fx_enc), 7);
        check("fp_grant80", 32'(fx_grant), 32'h80);
        cyc_fx(8'h00, 1'b1);
        check("fp_enc5", 32'(fx_enc), 5);
        cyc_fx(8'h00, 1'b1);
        check("fp_drain_valid", 32'(fx_valid), 0);
        check("fp_drain_busy", 32'(fx_busy), 0);

        // 3. Backpressure: no preemption by a higher channel.
        exp_fx.push_back(3'd2);
        exp_fx.push_back(3'd6);
        cyc_fx(8'h04, 1'b0);
        cyc_fx(8'h00, 1'b0);
        check("bp_enc2", 32'(fx_enc), 2);
        cyc_fx(8'h40, 1'b0);
        check("bp_hold_enc", 32'(fx_enc), 2);
        check("bp_pending44", 32'(fx_pend), 32'h44);
        cyc_fx(8'h00, 1'b0);
        check("bp_hold_grant", 32'(fx_grant), 32'h04);
        cyc_fx(8'h00, 1'b1);
        check("bp_enc6", 32'(fx_enc), 6);
        cyc_fx(8'h00, 1'b1);
        check("bp_drain_busy", 32'(fx_busy), 0);

        // 4a. Round-robin sweep from ptr=0.
        for (int k = 0; k < 8; k++) exp_rr.push_back(3'(k));
        cyc_rr(8'hFF, 1'b1);
        for (int k = 0; k < 8; k++) begin
            cyc_rr(8'h00, 1'b1);
            check("rr_sweep_valid", 32'(rr_valid), 1);
            check("rr_sweep_enc", 32'(rr_enc), 32'(k));
        end
        cyc_rr(8'h00, 1'b1);
        check("rr_sweep_done", 32'(rr_valid), 0);

        // 4b. Grant channel 2 to move ptr to 3, then bits 1 and 6 -> 6 then 1.
        exp_rr.push_back(3'd2);
        cyc_rr(8'h04, 1'b1);
        cyc_rr(8'h00, 1'b1);
        check("rr_enc2", 32'(rr_enc), 2);
        cyc_rr(8'h00, 1'b1);
        exp_rr.push_back(3'd6);
        exp_rr.push_back(3'd1);
        cyc_rr(8'h42, 1'b1);
        cyc_rr(8'h00, 1'b1);
        check("rr_enc6", 32'(rr_enc), 6);
        cyc_rr(8'h00, 1'b1);
        check("rr_wrap_enc1", 32'(rr_enc), 1);
        cyc_rr(8'h00, 1'b1);
        check("rr_done_busy", 32'(rr_busy), 0);

        // 5. Re-request on the same edge the grant is accepted: set wins.
        exp_fx.push_back(3'd3);
        exp_fx.push_back(3'd3);
        cyc_fx(8'h08, 1'b1);
        cyc_fx(8'h00, 1'b1);
        check("sc_enc3", 32'(fx_enc), 3);
        cyc_fx(8'h08, 1'b1);
        check("sc_pending_kept", 32'(fx_pend), 32'h08);
        check("sc_slot_empty", 32'(fx_valid), 0);
        cyc_fx(8'h00, 1'b1);
        check("sc_regrant", 32'(fx_enc), 3);
        check("sc_regrant_valid", 32'(fx_valid), 1);
        cyc_fx(8'h00, 1'b1);
        check("sc_drain", 32'(fx_busy), 0);

        // 6. Asynchronous reset between edges while work is outstanding.
        cyc_fx(8'h0F, 1'b0);
        cyc_fx(8'h00, 1'b0);
        check("ar_pre_pending", 32'(fx_pend), 32'h0F);
        check("ar_pre_valid", 32'(fx_valid), 1);
        check("ar_pre_enc", 32'(fx_enc), 3);
        #1 rst = 1'b1;
        #1;
        check("ar_valid", 32'(fx_valid), 0);
        check("ar_enc", 32'(fx_enc), 0);
        check("ar_grant", 32'(fx_grant), 0);
        check("ar_pending", 32'(fx_pend), 0);
        check("ar_busy", 32'(fx_busy), 0);
        @(posedge clk); #2;
        rst = 1'b0;
        exp_fx.push_back(3'd4);
        cyc_fx(8'h10, 1'b1);
        cyc_fx(8'h00, 1'b1);
        check("ar_resume_enc", 32'(fx_enc), 4);
        check("ar_resume_valid", 32'(fx_valid), 1);
        cyc_fx(8'h00, 1'b1);
        check("ar_resume_idle", 32'(fx_busy), 0);

        // Drain: every expected grant must have been seen, within a bound.
        for (int k = 0; k < 20 && (exp_fx.size() != 0 || exp_rr.size() != 0); k++) begin
            @(posedge clk);
        end
        check("sb_fx_empty", 32'(exp_fx.size()), 0);
        check("sb_rr_empty", 32'(exp_rr.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
